// File: rtl/gpu_mem_pkg.sv
// Shared memory-map constants, pixel/chunk geometry and the scanout FSM
// state type for the layer-buffer blocks.
package gpu_mem_pkg;

    localparam int ADDR_SIZE_BITS  = 24;
    localparam int WORD_SIZE_BYTES = 3;
    localparam int DATA_SIZE_WORDS = 64;
    localparam int READ_LATENCY    = 2;

    localparam int PIXEL_BITS = WORD_SIZE_BYTES * 8;
    localparam int CHUNK_BITS = PIXEL_BITS * DATA_SIZE_WORDS;

    localparam logic [ADDR_SIZE_BITS-1:0] LAYER1_BASE   = 24'h000000;
    localparam logic [ADDR_SIZE_BITS-1:0] LAYER2_BASE   = 24'h010000;
    localparam logic [ADDR_SIZE_BITS-1:0] TEXTURE1_BASE = 24'h020000;
    localparam logic [ADDR_SIZE_BITS-1:0] TEXTURE2_BASE = 24'h021000;
    localparam logic [ADDR_SIZE_BITS-1:0] TEXTURE3_BASE = 24'h022000;

    localparam int ROW_STRIDE = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } scanout_state_t;

    // Base word address of the selected layer buffer.
    function automatic logic [ADDR_SIZE_BITS-1:0] layer_base(input logic layer);
        return layer ? LAYER2_BASE : LAYER1_BASE;
    endfunction

    // Word address of pixel (x, y); the 16-bit offset keeps every access
    // inside the 64K-word layer region.
    function automatic logic [ADDR_SIZE_BITS-1:0] chunk_address(
        input logic       layer,
        input logic [7:0] y,
        input logic [7:0] x
    );
        logic [15:0] offset;
        offset = 16'(y) * 16'(ROW_STRIDE) + 16'(x);
        return layer_base(layer) + {8'h00, offset};
    endfunction

endpackage

// File: rtl/scanout_chunk_buffer.sv
// Holds one SRAM chunk (64 pixels) and selects the pixel being streamed.
module scanout_chunk_buffer
    import gpu_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CHUNK_BITS-1:0] load_data,
    input  logic [5:0]            sel,
    output logic [PIXEL_BITS-1:0] pixel
);

    logic [CHUNK_BITS-1:0] chunk_r;
    logic [10:0]           bit_idx_s;

    // Capture a whole chunk when the read completes; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_r <= '0;
        end else if (load) begin
            chunk_r <= load_data;
        end
    end

    // Bit offset of the selected pixel: sel * 24 = sel * 16 + sel * 8.
    always_comb begin
        bit_idx_s = {1'b0, sel, 4'b0000} + {2'b00, sel, 3'b000};
    end

    assign pixel = chunk_r[bit_idx_s +: PIXEL_BITS];

endmodule

// File: rtl/layer_scanout.sv
// Streams a full 256x256 layer buffer out of SRAM in row-major order:
// reads one 64-pixel chunk, serialises it over a valid/ready handshake,
// then fetches the next chunk. No prefetch, read-only.
module layer_scanout
    import gpu_mem_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      layer_num,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      read_enable,
    output logic [ADDR_SIZE_BITS-1:0] address,
    input  logic [CHUNK_BITS-1:0]     read_data,
    output logic [PIXEL_BITS-1:0]     pixel_data,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic [7:0]                pixel_x,
    output logic [7:0]                pixel_y
);

    localparam logic [3:0] WAIT_LAST = 4'(READ_LATENCY - 1);

    scanout_state_t            state_r;
    logic                      layer_r;
    logic [7:0]                x_r;
    logic [7:0]                y_r;
    logic [3:0]                wait_r;
    logic                      busy_r;
    logic                      frame_done_r;
    logic                      read_enable_r;
    logic [ADDR_SIZE_BITS-1:0] address_r;
    logic                      pixel_valid_r;

    logic                      load_s;
    logic [7:0]                x_next_s;
    logic [7:0]                y_next_s;
    logic                      last_pixel_s;
    logic                      chunk_end_s;

    // Next-coordinate and chunk/frame boundary decode for the handshake.
    always_comb begin
        load_s       = (state_r == ST_READ) && (wait_r == WAIT_LAST);
        x_next_s     = x_r + 8'd1;
        last_pixel_s = (x_r == 8'hFF) && (y_r == 8'hFF);
        chunk_end_s  = (x_r[5:0] == 6'h3F);
        if (x_r == 8'hFF) begin
            y_next_s = y_r + 8'd1;
        end else begin
            y_next_s = y_r;
        end
    end

    // Scan FSM with registered handshake, SRAM and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            layer_r       <= 1'b0;
            x_r           <= 8'd0;
            y_r           <= 8'd0;
            wait_r        <= 4'd0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            read_enable_r <= 1'b0;
            address_r     <= '0;
            pixel_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (start) begin
                        layer_r       <= layer_num;
                        x_r           <= 8'd0;
                        y_r           <= 8'd0;
                        wait_r        <= 4'd0;
                        busy_r        <= 1'b1;
                        read_enable_r <= 1'b1;
                        address_r     <= chunk_address(layer_num, 8'd0, 8'd0);
                        state_r       <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (load_s) begin
                        wait_r        <= 4'd0;
                        read_enable_r <= 1'b0;
                        pixel_valid_r <= 1'b1;
                        state_r       <= ST_STREAM;
                    end else begin
                        wait_r <= wait_r + 4'd1;
                    end
                end
                ST_STREAM: begin
                    if (pixel_ready) begin
                        x_r <= x_next_s;
                        y_r <= y_next_s;
                        if (last_pixel_s) begin
                            pixel_valid_r <= 1'b0;
                            frame_done_r  <= 1'b1;
                            state_r       <= ST_DONE;
                        end else if (chunk_end_s) begin
                            pixel_valid_r <= 1'b0;
                            read_enable_r <= 1'b1;
                            wait_r        <= 4'd0;
                            address_r     <= chunk_address(layer_r, y_next_s, x_next_s);
                            state_r       <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    frame_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    busy_r        <= 1'b0;
                    frame_done_r  <= 1'b0;
                    read_enable_r <= 1'b0;
                    pixel_valid_r <= 1'b0;
                end
            endcase
        end
    end

    scanout_chunk_buffer u_chunk_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (read_data),
        .sel       (x_r[5:0]),
        .pixel     (pixel_data)
    );

    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign read_enable = read_enable_r;
    assign address     = address_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_x     = x_r;
    assign pixel_y     = y_r;

endmodule

// File: doc/layer_scanout.md
Name: layer_scanout

Overview:
- Reader counterpart to the fill engine: streams one full 256x256 layer buffer out of SRAM, row-major, one 24-bit pixel per handshake.
- Issues 64-word chunk reads on the same SRAM read port (read_enable/address/read_data), buffers each chunk, then serialises it.
- Feeds the display/compositing path downstream of the layer buffers.

Parameters:
- ADDR_SIZE_BITS, 24, SRAM address width.
- WORD_SIZE_BYTES, 3, bytes per pixel word.
- DATA_SIZE_WORDS, 64, pixel words per SRAM access.
- READ_LATENCY, 2, cycles read_enable and address are held; read_data is valid on the last of them.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin frame scan; sampled only in IDLE.
- layer_num  in  1  0 = layerbuffer1 (base 0), 1 = layerbuffer2 (base 65536); latched at start.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel handshake.
- read_enable  out  1  SRAM read strobe.
- address  out  ADDR_SIZE_BITS  SRAM word address of the current chunk.
- read_data  in  WORD_SIZE_BYTES*DATA_SIZE_WORDS*8  chunk data; pixel j is at bits [j*24 +: 24].
- pixel_data  out  24  current pixel colour.
- pixel_valid  out  1  pixel_data, pixel_x and pixel_y are valid.
- pixel_ready  in  1  downstream accepts the pixel when pixel_valid and pixel_ready are both high.
- pixel_x  out  8  column of the current pixel.
- pixel_y  out  8  row of the current pixel.

Behaviour:
- Reset: state IDLE; all outputs 0; x, y, wait counter and chunk buffer cleared.
- States: IDLE, READ, STREAM, DONE.
- IDLE -> READ when start=1. Latch layer_num at that edge; x=0, y=0.
- READ: read_enable=1; address = base + y*256 + x, where x is a multiple of 64.
  - Hold address for exactly READ_LATENCY cycles.
  - On the last READ cycle, capture read_data into the chunk buffer, then go to STREAM.
- STREAM: pixel_valid=1; pixel_data = buffer[(x mod 64)*24 +: 24]; pixel_x=x; pixel_y=y.
  - On handshake, x increments (8-bit).
  - If (x mod 64) was 63 and the pixel was not the last of the frame, go to READ. If x wrapped 255 -> 0, y increments.
  - If x=255 and y=255, go to DONE.
- DONE: frame_done=1 for one cycle, busy=1, then IDLE.
- Timing: start sampled at edge N gives read_enable high in cycles N+1..N+READ_LATENCY and first pixel_valid in cycle N+READ_LATENCY+1.
  - Each chunk costs READ_LATENCY+64 cycles with pixel_ready held high.
  - Full frame at READ_LATENCY=2: last handshake in cycle N+67584, frame_done in cycle N+67585.
- Backpressure: while pixel_valid=1 and pixel_ready=0, pixel_data, pixel_x and pixel_y are held. No pixel is skipped or repeated.
- No prefetch: pixel_valid is 0 in READ and DONE.
- Address arithmetic uses an unsigned 16-bit offset plus the base. The last chunk is at base+0xFFC0, and the offset never overflows into another region.
- start while busy is ignored; a change on layer_num mid-frame is ignored.
- rst mid-frame: synchronous return to IDLE and all outputs 0 on that edge, with no frame_done.
- read_enable and pixel_valid are never high in the same cycle. The block never writes.

Decomposition:
- Package gpu_mem_pkg holds:
  - LAYER1_BASE=0, LAYER2_BASE=65536, TEXTURE1_BASE=131072, TEXTURE2_BASE=135168, TEXTURE3_BASE=139264.
  - ROW_STRIDE=256.
  - The scanout_state_t enum.
- One sub-module, scanout_chunk_buffer: the 1536-bit load-enabled register plus the 6-bit-indexed 24-bit pixel select mux.

Test Plan:
- Reset: assert rst for 2 cycles with pixel_ready=1 -> all outputs 0, busy=0; no read_enable for 10 cycles with start=0.
- Layer 0, first chunk: memory model returns word j = 24'h000100+j at address 0; start with layer_num=0 -> address 0x000000 with read_enable for 2 cycles; then pixels 0x000100..0x00013F at x=0..63, y=0; next address 0x000040.
- Layer 1 addressing: start with layer_num=1 -> chunk addresses 0x010000, 0x010040, 0x010080, 0x0100C0, then 0x010100 with pixel_y=1.
- Backpressure: drop pixel_ready for 5 cycles at pixel_x=10 -> pixel_valid stays high and data/x are held; after release pixel_x=11 follows with no gap or duplicate.
- Full frame, pixel_ready always 1: exactly 65536 handshakes and 1024 reads, the last at 0x01FFC0 for layer 1. frame_done pulses once at N+67585, then busy=0. A start pulsed mid-frame is ignored.
- rst asserted at y=3, x=130 -> next cycle all outputs 0 and state IDLE, with no frame_done. A new start then restarts the scan at address base+0.
